// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings,
// amount-width helper and op classification helpers.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHOP_SLL = 3'b000,
    SHOP_SRL = 3'b001,
    SHOP_SRA = 3'b010,
    SHOP_ROL = 3'b011,
    SHOP_ROR = 3'b100
  } shop_e;

  function automatic int amt_w(input int width);
    return $clog2(width);
  endfunction

  // Left ops reuse the right-shift core on bit-reversed data.
  function automatic logic is_left(input logic [2:0] op);
    return (op == SHOP_SLL) || (op == SHOP_ROL);
  endfunction

  function automatic logic is_rot(input logic [2:0] op);
    return (op == SHOP_ROL) || (op == SHOP_ROR);
  endfunction

  function automatic logic is_sra(input logic [2:0] op);
    return op == SHOP_SRA;
  endfunction

  // Codes above SHOP_ROR pass data through unchanged.
  function automatic logic is_shift(input logic [2:0] op);
    return op <= SHOP_ROR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log stage of the right-shift core: shifts right by SHIFT when enabled,
// filling vacated bits with the wrapped low bits or a replicated fill bit.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic             i_rot,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [SHIFT-1:0] w_ins;

  assign w_ins  = i_rot ? i_data[SHIFT-1:0] : {SHIFT{i_fill}};
  assign o_data = i_en ? {w_ins, i_data[WIDTH-1:SHIFT]} : i_data;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake,
// a register every REG_EVERY log stages and per-slot bubble collapse.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [amt_w(WIDTH)-1:0]  in_amt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int AW   = amt_w(WIDTH);
  localparam int NSTG = AW;
  localparam int NREG = (NSTG + REG_EVERY - 1) / REG_EVERY;
  localparam int CW   = 3 + AW + 1;

  logic [NREG-1:0]  r_vld;
  logic [NREG-1:0]  w_vld_src;
  logic [NREG-1:0]  w_en;
  logic [CW-1:0]    w_ctl_src [NREG];
  logic [WIDTH-1:0] w_dat_src [NREG];
  logic [TAG_W-1:0] w_tag_src [NREG];
  logic [WIDTH-1:0] w_stg_out [NSTG];
  logic [WIDTH-1:0] w_in_rev;
  logic [WIDTH-1:0] w_last_raw;
  logic [WIDTH-1:0] w_last_rev;
  logic [2:0]       w_last_op;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  // Control word per slot: {op, amount, sign of original operand}.
  assign w_in_rev     = {<<{in_data}};
  assign w_ctl_src[0] = {in_op, in_amt, in_data[WIDTH-1]};
  assign w_dat_src[0] = is_left(in_op) ? w_in_rev : in_data;
  assign w_tag_src[0] = in_tag;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int G = k / REG_EVERY;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_din;
    assign w_op = w_ctl_src[G][CW-1 -: 3];
    if (k % REG_EVERY == 0) begin : g_head
      assign w_din = w_dat_src[G];
    end else begin : g_chain
      assign w_din = w_stg_out[k-1];
    end
    shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << (NSTG - 1 - k))
    ) u_shift_stage (
      .i_data (w_din),
      .i_en   (w_ctl_src[G][NSTG-k] & is_shift(w_op)),
      .i_rot  (is_rot(w_op)),
      .i_fill (w_ctl_src[G][0] & is_sra(w_op)),
      .o_data (w_stg_out[k])
    );
  end

  // Inner slots carry data and control unreset; r_vld alone qualifies them.
  for (genvar g = 0; g < NREG - 1; g++) begin : g_slot
    localparam int LAST_STG = (g + 1) * REG_EVERY - 1;
    logic [CW-1:0]    r_ctl;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;
    always_ff @(posedge clk) begin
      if (w_en[g] && w_vld_src[g]) begin
        r_ctl  <= w_ctl_src[g];
        r_data <= w_stg_out[LAST_STG];
        r_tag  <= w_tag_src[g];
      end
    end
    assign w_ctl_src[g+1] = r_ctl;
    assign w_dat_src[g+1] = r_data;
    assign w_tag_src[g+1] = r_tag;
  end

  // A slot loads when empty or when the slot below it is loading too.
  always_comb begin
    w_vld_src    = '0;
    w_en         = '0;
    w_vld_src[0] = in_valid;
    for (int g = 1; g < NREG; g++) begin
      w_vld_src[g] = r_vld[g-1];
    end
    w_en[NREG-1] = !r_vld[NREG-1] || out_ready;
    for (int g = NREG - 2; g >= 0; g--) begin
      w_en[g] = !r_vld[g] || w_en[g+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= (w_en & w_vld_src) | (~w_en & r_vld);
    end
  end

  assign w_last_op  = w_ctl_src[NREG-1][CW-1 -: 3];
  assign w_last_raw = w_stg_out[NSTG-1];
  assign w_last_rev = {<<{w_last_raw}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (w_en[NREG-1] && w_vld_src[NREG-1]) begin
      r_out_data <= is_left(w_last_op) ? w_last_rev : w_last_raw;
      r_out_tag  <= w_tag_src[NREG-1];
    end
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_vld[NREG-1];
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors on the default build,
// random traffic on WIDTH 8 / REG_EVERY 1 and WIDTH 64 / REG_EVERY 3 builds.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic [4:0]  in_tag, out_tag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rnd_go = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int a,
                                            input logic [2:0] op, input int w);
    logic [63:0] mask, d, r;
    logic signed [63:0] sx;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = d_in & mask;
    case (op)
      3'b000:  r = d << a;
      3'b001:  r = d >> a;
      3'b010:  begin sx = d[w-1] ? (d | ~mask) : d; r = sx >>> a; end
      3'b011:  r = (d << a) | (d >> (w - a));
      3'b100:  r = (d >> a) | (d << (w - a));
      default: r = d;
    endcase
    return r & mask;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                      input logic [4:0] t, input logic [31:0] e, input bit lat);
    exp_t it;
    int   n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = t;
    forever begin
      #2;
      if (in_ready) begin
        it.data = e; it.tag = t; it.cyc = cyc; it.lat = lat;
        q.push_back(it);
        break;
      end
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: tag %0d not accepted, required acceptance", t);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results still pending, required 0", name, q.size());
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor for the default build; samples just before the rising edge.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;
    exp_t        e;
    prev_stall = 1'b0; prev_data = '0; prev_tag = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (prev_stall && out_valid) begin
          chk("stall_data", 64'(out_data), 64'(prev_data));
          chk("stall_tag", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got data 0x%0h tag %0d, required no result", out_data, out_tag);
          end else begin
            e = q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_tag", 64'(out_tag), 64'(e.tag));
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      cyc++;
    end
  end

  // Random traffic on two alternative builds, checked against ref_shift.
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int W  = (g == 0) ? 8 : 64;
    localparam int RE = (g == 0) ? 1 : 3;
    localparam int AW = $clog2(W);
    logic          iv, ir, ov, ordy;
    logic [W-1:0]  id, od;
    logic [AW-1:0] ia;
    logic [2:0]    io;
    logic [4:0]    it, ot;
    logic [W+4:0]  rq[$];
    bit            done = 1'b0;

    shifter_pipe #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .in_data(id), .in_amt(ia), .in_op(io), .in_tag(it),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(ot)
    );

    initial begin
      iv = 1'b0; id = '0; ia = '0; io = 3'd0; it = 5'd0; ordy = 1'b0;
      wait (rnd_go);
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        #1;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        id   = W'({$urandom, $urandom});
        ia   = AW'($urandom);
        io   = 3'($urandom_range(0, 7));
        it   = 5'($urandom);
        #1;
        if (iv && ir) rq.push_back({it, W'(ref_shift(64'(id), int'(ia), io, W))});
      end
      @(negedge clk);
      #1;
      iv = 1'b0; ordy = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (rq.size() != 0) begin
        errors++;
        $display("FAIL rnd_drain_w%0d: %0d results pending, required 0", W, rq.size());
      end
      done = 1'b1;
    end

    initial begin
      logic [W+4:0] e;
      forever begin
        @(negedge clk);
        #3;
        if (rst_n && ov && ordy) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd_unexpected_w%0d: got 0x%0h, required no result", W, od);
          end else begin
            e = rq.pop_front();
            chk((g == 0) ? "rnd_data_w8" : "rnd_data_w64", 64'(od), 64'(e[W-1:0]));
            chk((g == 0) ? "rnd_tag_w8" : "rnd_tag_w64", 64'(ot), 64'(e[W+4:W]));
          end
        end
      end
    end
  end

  // Directed vectors: op, operand, amount, tag, hand-computed result.
  logic [2:0]  v_op  [15] = '{3'b010, 3'b100, 3'b011, 3'b000, 3'b001, 3'b111, 3'b010, 3'b001,
                              3'b011, 3'b010, 3'b100, 3'b000, 3'b101, 3'b010, 3'b011};
  logic [31:0] v_dat [15] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 32'hFFFF_FFFF,
                              32'h1234_5678, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'h1234_5678, 32'hF000_0000, 32'h1234_5678, 32'h0000_0001,
                              32'hA5A5_A5A5, 32'h8000_0000, 32'h0000_ABCD};
  logic [4:0]  v_amt [15] = '{5'd4, 5'd1, 5'd4, 5'd31, 5'd0, 5'd5, 5'd31, 5'd31,
                              5'd0, 5'd0, 5'd16, 5'd5, 5'd31, 5'd31, 5'd8};
  logic [31:0] v_exp [15] = '{32'hF800_0000, 32'h8000_0000, 32'h0000_0018, 32'h8000_0000,
                              32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0001,
                              32'h1234_5678, 32'hF000_0000, 32'h5678_1234, 32'h0000_0020,
                              32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h00AB_CD00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = 3'd0; in_tag = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2 chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rnd_go = 1'b1;

    for (int i = 0; i < 15; i++) begin
      send(v_op[i], v_dat[i], v_amt[i], (i == 0) ? 5'd3 : 5'(i + 3), v_exp[i], 1'b1);
    end
    drain("directed_drain");

    #1 out_ready = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) send(3'b000, 32'd1, 5'(i), 5'(10 + i), 32'd1 << i, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1 chk("full_release_in_ready", 64'(in_ready), 64'd1);
      end
    join
    drain("stall_drain");

    n = 0;
    while (!(g_rnd[0].done && g_rnd[1].done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(g_rnd[0].done && g_rnd[1].done)) begin
      errors++;
      $display("FAIL rnd_timeout: random traffic unfinished, required finished");
    end

    @(negedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(3'b001, 32'hF0F0_0000, 5'd4, 5'(20 + i), 32'h0F0F_0000, 1'b0);
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk("async_reset_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    #1 out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    send(3'b100, 32'h0000_0001, 5'd1, 5'd30, 32'h8000_0000, 1'b1);
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter REG_EVERY, default 2, log-stages between pipeline registers; 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 5, width of opaque sideband tag.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_amt  input  log2(WIDTH)  shift amount.
REQ-010 SHALL have port in_op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 pass-through.
REQ-011 SHALL have port in_tag  input  TAG_W  carried unchanged to out_tag.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have port out_data  output  WIDTH  result.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.

Function
REQ-016 SHALL compute log2(WIDTH) binary stages, largest shift (WIDTH/2) first, smallest (1) last.
REQ-017 SHALL implement left ops by bit-reversal before and after the right-shift core.
REQ-018 SHALL fill vacated bits: zero for SLL/SRL; in_data[WIDTH-1] for SRA; wrapped bits for ROL/ROR.
REQ-019 SHALL insert a register after every REG_EVERY stages and after the last stage; latency L = ceil(log2(WIDTH)/REG_EVERY) cycles (default 3).
REQ-020 SHALL carry valid, op, remaining amount bits, sign bit and tag alongside data in every register.
REQ-021 SHALL advance each register slot when the downstream slot is empty or advancing (per-slot bubble collapse); the output slot advances when out_ready or !out_valid.
REQ-022 SHALL drive in_ready = first slot empty or advancing; combinational from out_ready is permitted.
REQ-023 SHALL sustain one accepted request per cycle with out_ready held high.
REQ-024 SHALL hold out_data/out_tag stable while out_valid && !out_ready.
REQ-025 SHALL deliver results in acceptance order; no drop, no duplication.
REQ-026 SHALL treat in_amt = 0 as identity for all ops.
REQ-027 SHALL accept a new request in the same cycle the final result is consumed when full (no bubble).

Reset
REQ-028 SHALL clear all valid bits immediately on rst_n low, independent of clk.
REQ-029 SHALL reset out_valid 0, out_data 0, out_tag 0; in_ready 1 after reset release.
REQ-030 SHALL discard all in-flight requests when reset asserts mid-operation.
REQ-031 SHALL NOT require data-path registers other than the output registers to be reset.

Structure
REQ-032 SHALL place op encodings (SHOP_SLL...SHOP_ROR) and the WIDTH-to-amount-width function in shared package shifter_pkg.
REQ-033 SHALL use one sub-module, shift_stage (parameter SHIFT, combinational, one log stage with fill input), instantiated per stage.

Verification
REQ-034 SHALL cover: SRA 0x80000000 by 4, tag 3 -> out 0xF8000000, tag 3, exactly 3 cycles after acceptance.
REQ-035 SHALL cover: ROR 0x00000001 by 1 -> 0x80000000; ROL 0x80000001 by 4 -> 0x00000018.
REQ-036 SHALL cover: SLL 0xFFFFFFFF by 31 -> 0x80000000; SRL 0x12345678 by 0 -> 0x12345678; op 111 -> input unchanged.
REQ-037 SHALL cover: 6 back-to-back requests with out_ready low 5 cycles -> in_ready low once all slots full, all 6 results delivered in order, out_data stable while stalled.
REQ-038 SHALL cover: rst_n low mid-flight with 3 requests pending -> out_valid 0 without a clock edge; no stale result after release.
REQ-039 SHALL cover: random ops/amounts against a reference model for WIDTH 8, 32, 64 and REG_EVERY 1 and 3.
